// File: rtl/weight_loader.sv
// Loads KERN_S coefficients from a FIFO into a register file, then serves reads; rd_q has 1-cycle latency.
// The FIFO is popped only in LOAD with a valid head and no reload; READY leaves upstream data untouched.
module weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int KERN_S     = 9,
  parameter int AW         = $clog2(KERN_S)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  input  logic                  reload,
  output logic                  weights_ready,
  output logic                  load_done,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_ce,
  output logic [DATA_WIDTH-1:0] rd_q
);

  typedef enum logic {LOAD = 1'b0, READY = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(KERN_S - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(KERN_S);

  state_t                state, state_nxt;
  logic [AW-1:0]         wr_cnt, wr_cnt_nxt;
  logic                  pop;
  logic                  done_nxt;
  logic [DATA_WIDTH-1:0] mem [KERN_S];

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    pop        = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      LOAD: begin
        // A reload discards the partial kernel and wins over a pending pop.
        if (reload) begin
          wr_cnt_nxt = '0;
        end else if (input_V_empty_n) begin
          pop = 1'b1;
          if (wr_cnt == LAST_IDX) begin
            wr_cnt_nxt = '0;
            state_nxt  = READY;
            done_nxt   = 1'b1;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      READY: begin
        if (reload) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Gated by reset so nothing is consumed while the block is held in reset.
  assign input_V_read = pop & ap_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= LOAD;
      wr_cnt        <= '0;
      weights_ready <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_cnt        <= wr_cnt_nxt;
      weights_ready <= (state_nxt == READY);
      load_done     <= done_nxt;
    end
  end

  // Coefficient storage is deliberately not reset.
  always_ff @(posedge ap_clk) begin
    if (input_V_read) begin
      mem[wr_cnt] <= input_V_dout;
    end
  end

  // Same-address read and write on one edge returns the old word.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_q <= '0;
    end else if (rd_ce) begin
      rd_q <= ({1'b0, rd_addr} < DEPTH) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter DATA_WIDTH, 16, coefficient width in bits.
REQ-002 Parameter KERN_S, 9, number of coefficients per kernel (KERN_S >= 2).
REQ-003 Parameter AW, $clog2(KERN_S), read/write address width.
REQ-004 ap_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 ap_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 input_V_dout  input  DATA_WIDTH  coefficient at the head of the upstream FIFO.
REQ-007 input_V_empty_n  input  1  high = FIFO head valid.
REQ-008 input_V_read  output  1  pops the FIFO head in the current cycle.
REQ-009 reload  input  1  single-cycle request to reload a fresh kernel.
REQ-010 weights_ready  output  1  high = all KERN_S coefficients stored.
REQ-011 load_done  output  1  one-cycle pulse on completion of a load.
REQ-012 rd_addr  input  AW  coefficient index for the read port.
REQ-013 rd_ce  input  1  read enable.
REQ-014 rd_q  output  DATA_WIDTH  registered read data.

Function
REQ-015 Storage SHALL be a KERN_S x DATA_WIDTH array plus a write counter wr_cnt (AW bits).
REQ-016 FSM SHALL have two states, LOAD and READY; reset state is LOAD with wr_cnt = 0.
REQ-017 In LOAD, input_V_read SHALL equal input_V_empty_n combinationally, unless reload is high that cycle.
REQ-018 Each LOAD cycle with input_V_read high SHALL write input_V_dout to mem[wr_cnt] and increment wr_cnt.
REQ-019 The pop with wr_cnt == KERN_S-1 SHALL store the word, clear wr_cnt to 0, and move to READY on that edge.
REQ-020 weights_ready SHALL be high in READY, low in LOAD, and registered; it rises the cycle after the final pop.
REQ-021 load_done SHALL pulse high for exactly one cycle, coincident with the first READY cycle.
REQ-022 In READY, input_V_read SHALL be 0; upstream data SHALL remain unconsumed.
REQ-023 reload in READY SHALL move the FSM to LOAD with wr_cnt = 0; weights_ready falls on the next cycle.
REQ-024 reload in LOAD SHALL reset wr_cnt to 0 and suppress that cycle's pop; a partial load SHALL be discarded.
REQ-025 An empty FIFO (empty_n = 0) in LOAD SHALL stall: no write, wr_cnt held, no timeout.
REQ-026 The read port SHALL operate in both states: rd_q <= mem[rd_addr] on an edge with rd_ce = 1, and hold otherwise.
REQ-027 rd_addr >= KERN_S with rd_ce = 1 SHALL load rd_q with 0.
REQ-028 When a read and a write hit the same address in one cycle, rd_q SHALL return the old contents (read-before-write).
REQ-029 No arithmetic is performed on data; coefficients are stored bit-exact.

Reset
REQ-030 While ap_rst_n = 0: input_V_read = 0, weights_ready = 0, load_done = 0, rd_q = 0, state = LOAD, wr_cnt = 0.
REQ-031 Array contents SHALL NOT be reset; they are undefined until the first complete load.
REQ-032 Reset asserted mid-load SHALL abort the load immediately; after release, loading restarts at index 0.
REQ-033 Deassertion SHALL take effect on the next rising edge with no additional wait cycles.

Verification
REQ-034 Continuous FIFO, KERN_S = 9, words 1..9 -> 9 pops in 9 cycles; weights_ready and load_done high the cycle after the last pop; rd_addr 0..8 returns 1..9, 1 cycle latency.
REQ-035 empty_n toggling 1,0,1,0 -> pops only when empty_n = 1; wr_cnt holds across gaps; contents 1..9 intact.
REQ-036 READY with the FIFO still holding 0xAAAA -> input_V_read stays 0; pulse reload, feed 9 x 0xAAAA -> weights_ready drops for the load, then every address reads 0xAAAA.
REQ-037 reload after 4 pops -> those 4 are discarded; the next 9 words land at addresses 0..8.
REQ-038 ap_rst_n low after 5 pops, then released -> all outputs 0 during reset; the next load starts at address 0.
REQ-039 rd_ce with rd_addr = 12 -> rd_q = 0; rd_ce = 0 -> rd_q holds its previous value.
